// File: rtl/stream_req_arbiter.sv
// stream_req_arbiter
//   Shares one filter/input SRAM read stream port between NUM_PE PE controllers.
//   Input requests win over filter requests; each class is round-robin from its
//   own pointer. One grant runs one burst of beats over mem_req/mem_gnt, then a
//   FIN cycle credits the per-PE done flag (exposed as *_finish levels).
//
//   Optional: `define FILTER_MULTICAST_EN -- a filter burst also credits every
//   other PE requesting the identical k/layer with its done flag still clear.
//
// Ports
//   clk, rst (async, active-low)
//   req_filter_valid/req_filter_k/req_layer : per-PE filter request + tag
//   req_input_valid                         : per-PE input request
//   filter_len/input_len                    : beats per burst (0 = skip burst)
//   mem_req/mem_gnt                         : beat handshake to buffer
//   mem_is_input/mem_pe/mem_k/mem_layer     : burst descriptor (stable in burst)
//   mem_beat                                : beat offset within burst
//   stream_filter_finish/stream_input_finish: per-PE done levels
//   busy                                    : high in BURST and FIN

// Per-PE done flags with the tag captured when the filter flag was set.
module stream_req_pe_flags #(
  parameter int K_W     = 6,
  parameter int LAYER_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flt_valid,
  input  logic [K_W-1:0]     flt_k,
  input  logic [LAYER_W-1:0] flt_layer,
  input  logic               in_valid,
  input  logic               set_flt,
  input  logic               set_in,
  output logic               flt_done,
  output logic               in_done
);
  logic [K_W-1:0]     tag_k;
  logic [LAYER_W-1:0] tag_layer;
  logic               flt_stale;

  // Request dropped or retagged: the credited burst no longer applies.
  assign flt_stale = !flt_valid || (flt_k != tag_k) || (flt_layer != tag_layer);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_done  <= 1'b0;
      in_done   <= 1'b0;
      tag_k     <= '0;
      tag_layer <= '0;
    end else begin
      if (set_flt) begin
        flt_done  <= 1'b1;
        tag_k     <= flt_k;
        tag_layer <= flt_layer;
      end else if (flt_stale) begin
        flt_done  <= 1'b0;
      end
      if (set_in)         in_done <= 1'b1;
      else if (!in_valid) in_done <= 1'b0;
    end
  end
endmodule

module stream_req_arbiter #(
  parameter int NUM_PE  = 4,
  parameter int K_W     = 6,
  parameter int LAYER_W = 3,
  parameter int LEN_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PE-1:0]         req_filter_valid,
  input  logic [NUM_PE*K_W-1:0]     req_filter_k,
  input  logic [NUM_PE*LAYER_W-1:0] req_layer,
  input  logic [NUM_PE-1:0]         req_input_valid,
  input  logic [LEN_W-1:0]          filter_len,
  input  logic [LEN_W-1:0]          input_len,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic                      mem_is_input,
  output logic [$clog2(NUM_PE)-1:0] mem_pe,
  output logic [K_W-1:0]            mem_k,
  output logic [LAYER_W-1:0]        mem_layer,
  output logic [LEN_W-1:0]          mem_beat,
  output logic [NUM_PE-1:0]         stream_filter_finish,
  output logic [NUM_PE-1:0]         stream_input_finish,
  output logic                      busy
);
  localparam int PE_W = $clog2(NUM_PE);
  localparam logic [PE_W-1:0] LAST_PE = PE_W'(NUM_PE - 1);
`ifdef FILTER_MULTICAST_EN
  localparam bit MCAST = 1'b1;
`else
  localparam bit MCAST = 1'b0;
`endif

  typedef enum logic [1:0] {ARB, BURST, FIN} state_t;
  state_t state;

  logic [NUM_PE-1:0][K_W-1:0]     k_vec;
  logic [NUM_PE-1:0][LAYER_W-1:0] layer_vec;
  logic [NUM_PE-1:0] flt_done, in_done, flt_elig, in_elig, set_flt, set_in;
  logic [PE_W-1:0]   rr_flt, rr_in, grant_pe, next_pe;
  logic [PE_W:0]     pick_in, pick_flt;
  logic              grant_any, grant_input, fin_in, fin_flt;
  logic [LEN_W-1:0]  grant_len, cur_len;

  // Returns {found, id}: first eligible id at or after ptr, wrapping.
  function automatic logic [PE_W:0] rr_pick(input logic [NUM_PE-1:0] elig,
                                            input logic [PE_W-1:0]   ptr);
    logic [PE_W:0]   res;
    logic [PE_W-1:0] p;
    int              idx;
    res = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_PE) idx = idx - NUM_PE;
      p = PE_W'(idx);
      if (!res[PE_W] && elig[p]) res = {1'b1, p};
    end
    return res;
  endfunction

  assign flt_elig    = req_filter_valid & ~flt_done;
  assign in_elig     = req_input_valid & ~in_done;
  assign pick_in     = rr_pick(in_elig, rr_in);
  assign pick_flt    = rr_pick(flt_elig, rr_flt);
  assign grant_input = pick_in[PE_W];
  assign grant_any   = pick_in[PE_W] | pick_flt[PE_W];
  assign grant_pe    = grant_input ? pick_in[PE_W-1:0] : pick_flt[PE_W-1:0];
  assign grant_len   = grant_input ? input_len : filter_len;
  assign cur_len     = mem_is_input ? input_len : filter_len;
  assign next_pe     = (mem_pe == LAST_PE) ? '0 : mem_pe + PE_W'(1);
  assign fin_in      = (state == FIN) && mem_is_input;
  assign fin_flt     = (state == FIN) && !mem_is_input;
  assign busy        = (state != ARB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB;
      mem_req      <= 1'b0;
      mem_is_input <= 1'b0;
      mem_pe       <= '0;
      mem_k        <= '0;
      mem_layer    <= '0;
      mem_beat     <= '0;
      rr_flt       <= '0;
      rr_in        <= '0;
    end else begin
      case (state)
        ARB: if (grant_any) begin
          mem_is_input <= grant_input;
          mem_pe       <= grant_pe;
          mem_k        <= k_vec[grant_pe];
          mem_layer    <= layer_vec[grant_pe];
          mem_beat     <= '0;
          // Zero-length burst: nothing to read, go straight to crediting.
          if (grant_len == '0) state <= FIN;
          else begin
            state   <= BURST;
            mem_req <= 1'b1;
          end
        end
        BURST: if (mem_gnt) begin
          if (mem_beat == cur_len - LEN_W'(1)) begin
            mem_req <= 1'b0;
            state   <= FIN;
          end else begin
            mem_beat <= mem_beat + LEN_W'(1);
          end
        end
        FIN: begin
          if (mem_is_input) rr_in  <= next_pe;
          else              rr_flt <= next_pe;
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    assign k_vec[g]     = req_filter_k[g*K_W +: K_W];
    assign layer_vec[g] = req_layer[g*LAYER_W +: LAYER_W];
    // Credit only if the request still stands with the tag the burst served.
    assign set_in[g]  = fin_in && (mem_pe == PE_W'(g)) && req_input_valid[g];
    assign set_flt[g] = fin_flt && req_filter_valid[g] && !flt_done[g] &&
                        (k_vec[g] == mem_k) && (layer_vec[g] == mem_layer) &&
                        (MCAST || (mem_pe == PE_W'(g)));

    stream_req_pe_flags #(.K_W(K_W), .LAYER_W(LAYER_W)) u_flags (
      .clk       (clk),
      .rst       (rst),
      .flt_valid (req_filter_valid[g]),
      .flt_k     (k_vec[g]),
      .flt_layer (layer_vec[g]),
      .in_valid  (req_input_valid[g]),
      .set_flt   (set_flt[g]),
      .set_in    (set_in[g]),
      .flt_done  (flt_done[g]),
      .in_done   (in_done[g])
    );
  end

  assign stream_filter_finish = flt_done;
  assign stream_input_finish  = in_done;
endmodule

// File: tb/tb_stream_req_arbiter.sv
// Randomized bench for stream_req_arbiter against a transaction-level model:
// one "current burst" record with beats remaining, done bits with captured
// tags, and per-class round-robin pointers as plain integers.
module tb_stream_req_arbiter;
  localparam int NUM_PE = 4, K_W = 6, LAYER_W = 3, LEN_W = 10, PE_W = 2;
`ifdef FILTER_MULTICAST_EN
  localparam bit MCAST = 1'b1;
`else
  localparam bit MCAST = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic [NUM_PE-1:0]         req_filter_valid, req_input_valid;
  logic [NUM_PE*K_W-1:0]     req_filter_k;
  logic [NUM_PE*LAYER_W-1:0] req_layer;
  logic [LEN_W-1:0]          filter_len, input_len, mem_beat;
  logic                      mem_req, mem_gnt, mem_is_input, busy;
  logic [PE_W-1:0]           mem_pe;
  logic [K_W-1:0]            mem_k;
  logic [LAYER_W-1:0]        mem_layer;
  logic [NUM_PE-1:0]         stream_filter_finish, stream_input_finish;

  stream_req_arbiter #(.NUM_PE(NUM_PE), .K_W(K_W), .LAYER_W(LAYER_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_filter_valid(req_filter_valid), .req_filter_k(req_filter_k),
    .req_layer(req_layer), .req_input_valid(req_input_valid),
    .filter_len(filter_len), .input_len(input_len),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_is_input(mem_is_input),
    .mem_pe(mem_pe), .mem_k(mem_k), .mem_layer(mem_layer), .mem_beat(mem_beat),
    .stream_filter_finish(stream_filter_finish),
    .stream_input_finish(stream_input_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // stimulus state
  int fv[NUM_PE], fk[NUM_PE], fl[NUM_PE], iv[NUM_PE];
  int gnt_mode;

  // model state
  typedef enum int {M_IDLE, M_BURST, M_FIN} phase_t;
  phase_t ph;
  int  cur_pe, cur_k, cur_l, blen, left, rr_f, rr_i;
  bit  cur_inp;
  bit  fd[NUM_PE], id[NUM_PE];
  int  tk[NUM_PE], tl[NUM_PE];

  function automatic logic [31:0] pack(input bit b[NUM_PE]);
    logic [31:0] v = '0;
    for (int i = 0; i < NUM_PE; i++) v[i] = b[i];
    return v;
  endfunction

  task automatic apply();
    for (int i = 0; i < NUM_PE; i++) begin
      req_filter_valid[i]                = fv[i][0];
      req_input_valid[i]                 = iv[i][0];
      req_filter_k[i*K_W +: K_W]         = K_W'(fk[i]);
      req_layer[i*LAYER_W +: LAYER_W]    = LAYER_W'(fl[i]);
    end
  endtask

  task automatic model_reset();
    ph = M_IDLE; cur_pe = 0; cur_k = 0; cur_l = 0; blen = 0; left = 0;
    rr_f = 0; rr_i = 0; cur_inp = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      fd[i] = 0; id[i] = 0; tk[i] = 0; tl[i] = 0;
      fv[i] = 0; iv[i] = 0; fk[i] = 5; fl[i] = 0;
    end
  endtask

  task automatic start_burst(input int p, input bit inp);
    cur_pe = p; cur_inp = inp; cur_k = fk[p]; cur_l = fl[p];
    blen = inp ? int'(input_len) : int'(filter_len);
    left = blen;
    ph = (blen == 0) ? M_FIN : M_BURST;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit nfd[NUM_PE], nid[NUM_PE];
    bit found;
    int p;
    for (int i = 0; i < NUM_PE; i++) begin
      nfd[i] = fd[i] && fv[i] != 0 && fk[i] == tk[i] && fl[i] == tl[i];
      nid[i] = id[i] && iv[i] != 0;
    end
    case (ph)
      M_IDLE: begin
        found = 0;
        for (int n = 0; n < NUM_PE; n++) begin
          p = (rr_i + n) % NUM_PE;
          if (!found && iv[p] != 0 && !id[p]) begin found = 1; start_burst(p, 1); end
        end
        for (int n = 0; n < NUM_PE; n++) begin
          p = (rr_f + n) % NUM_PE;
          if (!found && fv[p] != 0 && !fd[p]) begin found = 1; start_burst(p, 0); end
        end
      end
      M_BURST: if (mem_gnt) begin
        left--;
        if (left == 0) ph = M_FIN;
      end
      M_FIN: begin
        if (cur_inp) begin
          if (iv[cur_pe] != 0) nid[cur_pe] = 1;
          rr_i = (cur_pe + 1) % NUM_PE;
        end else begin
          for (int i = 0; i < NUM_PE; i++)
            if (fv[i] != 0 && fk[i] == cur_k && fl[i] == cur_l && !fd[i] &&
                (MCAST || i == cur_pe)) begin
              nfd[i] = 1; tk[i] = fk[i]; tl[i] = fl[i];
            end
          rr_f = (cur_pe + 1) % NUM_PE;
        end
        ph = M_IDLE;
      end
      default: ph = M_IDLE;
    endcase
    fd = nfd; id = nid;
  endtask

  task automatic check_outputs();
    chk("busy", busy, ph != M_IDLE);
    chk("mem_req", mem_req, ph == M_BURST);
    chk("flt_finish", stream_filter_finish, pack(fd));
    chk("in_finish", stream_input_finish, pack(id));
    if (ph == M_BURST) begin
      chk("mem_pe", mem_pe, cur_pe);
      chk("mem_is_input", mem_is_input, cur_inp);
      chk("mem_k", mem_k, cur_k);
      chk("mem_layer", mem_layer, cur_l);
      chk("mem_beat", mem_beat, blen - left);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NUM_PE; i++) begin
      if ($urandom_range(0, 9) == 0)  fv[i] = !fv[i];
      if ($urandom_range(0, 15) == 0) fk[i] = ($urandom_range(0, 1) != 0) ? 5 : 7;
      if ($urandom_range(0, 19) == 0) fl[i] = int'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) iv[i] = !iv[i];
    end
    mem_gnt = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    apply();
  endtask

  task automatic cycle();
    randomize_inputs();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  int flens[6] = '{4, 1, 3, 0, 2, 3};
  int ilens[6] = '{2, 1, 3, 2, 0, 1};

  initial begin
    filter_len = '0; input_len = '0; mem_gnt = 1'b0;
    model_reset(); apply();
    repeat (2) @(negedge clk);
    check_outputs();

    for (int seg = 0; seg < 6; seg++) begin
      // Reset between segments; lengths change only while held in reset.
      @(negedge clk);
      rst = 1'b0;
      model_reset(); apply();
      filter_len = LEN_W'(flens[seg]);
      input_len  = LEN_W'(ilens[seg]);
      gnt_mode   = (seg < 2) ? 0 : 1;
      #1 check_outputs();
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 500; c++) cycle();

      // Async reset in the middle of a burst.
      for (int c = 0; c < 300 && ph != M_BURST; c++) cycle();
      if (ph != M_BURST) chk("burst_timeout", 0, 1);
      else begin
        rst = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flt_finish", stream_filter_finish, 0);
        chk("rst_in_finish", stream_input_finish, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
